powerup_scheduler: RTL and testbench

POWERUP_SCHEDULER -- requirements
Module: powerup_scheduler

---
 rtl/powerup_pkg.sv | 16 +
 rtl/powerup_scheduler_if.sv | 31 +++
 rtl/powerup_scheduler_rr_arbiter.sv | 32 +++
 rtl/powerup_scheduler.sv | 132 +++++++++++++
 tb/tb_powerup_scheduler.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/powerup_pkg.sv
// Shared definitions for the power-up scheduler slice.
//   state_t          : scheduler states (IDLE, ACTIVE, COOLDOWN)
//   FRAME_W          : width of the frame counter (frames_left)
//   DEFAULT_NUM_REQ  : default number of power-up requesters
package powerup_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam int FRAME_W         = 8;
    localparam int DEFAULT_NUM_REQ = 4;

endpackage : powerup_pkg

// File: rtl/powerup_scheduler_if.sv
// Handshake bundle between a frame/requester source and the scheduler.
//   master : drives start_of_frame, req, cancel; observes scheduler status
//   slave  : the scheduler side (inputs above, status outputs below)
//   start_of_frame, req[NUM_REQ], cancel   -> scheduler
//   powerup_active, grant_id, grant_pulse,
//   frames_left[8], pending[NUM_REQ]       <- scheduler
interface powerup_scheduler_if #(
    parameter int NUM_REQ = 4
);
    import powerup_pkg::*;

    logic                       start_of_frame;
    logic [NUM_REQ-1:0]         req;
    logic                       cancel;
    logic                       powerup_active;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                       grant_pulse;
    logic [FRAME_W-1:0]         frames_left;
    logic [NUM_REQ-1:0]         pending;

    modport master (
        output start_of_frame, req, cancel,
        input  powerup_active, grant_id, grant_pulse, frames_left, pending
    );

    modport slave (
        input  start_of_frame, req, cancel,
        output powerup_active, grant_id, grant_pulse, frames_left, pending
    );

endinterface : powerup_scheduler_if

// File: rtl/powerup_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   request    : candidate vector, one bit per requester
//   last_grant : index of the most recent grant
//   winner     : first set request searching upward from last_grant+1 (wraps)
//   valid      : at least one request bit is set
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         request,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       valid
);

    localparam int IDW = $clog2(NUM_REQ);

    // Walk offsets from farthest to nearest so the nearest set bit overwrites last.
    always_comb begin
        winner = last_grant;
        valid  = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (request[IDW'((int'(last_grant) + i) % NUM_REQ)]) begin
                winner = IDW'((int'(last_grant) + i) % NUM_REQ);
                valid  = 1'b1;
            end else begin
                winner = winner;
                valid  = valid;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/powerup_scheduler.sv
// Frame-timed power-up scheduler: grants one requester at a time for
// POWERUP_FRAMES frames, then locks out grants for COOLDOWN_FRAMES frames.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : slave modport of powerup_scheduler_if (requests in, status out)
// All status outputs are driven straight from registers.
module powerup_scheduler
    import powerup_pkg::*;
#(
    parameter int NUM_REQ         = DEFAULT_NUM_REQ,
    parameter int POWERUP_FRAMES  = 40,
    parameter int COOLDOWN_FRAMES = 10
) (
    input  logic                clk,
    input  logic                reset,
    powerup_scheduler_if.slave  bus
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [FRAME_W-1:0] POWERUP_LOAD  = FRAME_W'(POWERUP_FRAMES);
    localparam logic [FRAME_W-1:0] COOLDOWN_LOAD = FRAME_W'(COOLDOWN_FRAMES);
    localparam logic [NUM_REQ-1:0] ONE_HOT_LSB   = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t             state_r;
    logic               active_r;
    logic [IDW-1:0]     grant_id_r;
    logic               grant_pulse_r;
    logic [FRAME_W-1:0] frames_r;
    logic [NUM_REQ-1:0] pending_r;

    logic [NUM_REQ-1:0] cand_s;
    logic [IDW-1:0]     winner_s;
    logic               valid_s;
    logic [NUM_REQ-1:0] win_mask_s;
    logic [NUM_REQ-1:0] own_mask_s;
    logic               own_req_s;
    logic               last_frame_s;

    assign cand_s       = pending_r | bus.req;
    assign win_mask_s   = ONE_HOT_LSB << winner_s;
    assign own_mask_s   = ONE_HOT_LSB << grant_id_r;
    assign own_req_s    = |(bus.req & own_mask_s);
    assign last_frame_s = bus.start_of_frame && (frames_r <= 8'd1);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .request    (cand_s),
        .last_grant (grant_id_r),
        .winner     (winner_s),
        .valid      (valid_s)
    );

    // Scheduler state machine and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            active_r      <= 1'b0;
            grant_id_r    <= IDW'(NUM_REQ - 1);
            grant_pulse_r <= 1'b0;
            frames_r      <= 8'd0;
            pending_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_s) begin
                        state_r       <= ACTIVE;
                        active_r      <= 1'b1;
                        grant_pulse_r <= 1'b1;
                        grant_id_r    <= winner_s;
                        frames_r      <= POWERUP_LOAD;
                        // Winner's bit clears even if its req arrives this cycle.
                        pending_r     <= cand_s & ~win_mask_s;
                    end else begin
                        active_r      <= 1'b0;
                        grant_pulse_r <= 1'b0;
                        frames_r      <= 8'd0;
                        pending_r     <= cand_s;
                    end
                end
                ACTIVE: begin
                    grant_pulse_r <= 1'b0;
                    // The owner's own req is a retrigger, never a pending request.
                    pending_r     <= pending_r | (bus.req & ~own_mask_s);
                    if (bus.cancel || (!own_req_s && last_frame_s)) begin
                        active_r <= 1'b0;
                        if (COOLDOWN_FRAMES > 0) begin
                            state_r  <= COOLDOWN;
                            frames_r <= COOLDOWN_LOAD;
                        end else begin
                            state_r  <= IDLE;
                            frames_r <= 8'd0;
                        end
                    end else if (own_req_s) begin
                        frames_r <= POWERUP_LOAD;
                    end else if (bus.start_of_frame) begin
                        frames_r <= frames_r - 8'd1;
                    end else begin
                        frames_r <= frames_r;
                    end
                end
                COOLDOWN: begin
                    active_r      <= 1'b0;
                    grant_pulse_r <= 1'b0;
                    pending_r     <= cand_s;
                    if (last_frame_s) begin
                        state_r  <= IDLE;
                        frames_r <= 8'd0;
                    end else if (bus.start_of_frame) begin
                        frames_r <= frames_r - 8'd1;
                    end else begin
                        frames_r <= frames_r;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    active_r      <= 1'b0;
                    grant_pulse_r <= 1'b0;
                    frames_r      <= 8'd0;
                    pending_r     <= '0;
                end
            endcase
        end
    end

    assign bus.powerup_active = active_r;
    assign bus.grant_id       = grant_id_r;
    assign bus.grant_pulse    = grant_pulse_r;
    assign bus.frames_left    = frames_r;
    assign bus.pending        = pending_r;

endmodule : powerup_scheduler

// File: tb/tb_powerup_scheduler.sv
// Self-checking bench for powerup_scheduler (NUM_REQ=4, POWERUP_FRAMES=3,
// COOLDOWN_FRAMES=2): directed scenarios followed by random traffic, every
// cycle compared against a frame-level reference model.
module tb_powerup_scheduler;

    localparam int N  = 4;
    localparam int PF = 3;
    localparam int CF = 2;

    logic clk;
    logic reset;

    powerup_scheduler_if #(.NUM_REQ(N)) bus ();

    powerup_scheduler #(
        .NUM_REQ         (N),
        .POWERUP_FRAMES  (PF),
        .COOLDOWN_FRAMES (CF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: phase 0 = idle, 1 = powered up, 2 = lockout.
    int       m_phase;
    int       m_owner;
    int       m_left;
    bit [3:0] m_pend;
    bit       m_pulse;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_owner = N - 1;
        m_left  = 0;
        m_pend  = 4'b0000;
        m_pulse = 1'b0;
    endtask

    task automatic end_powerup();
        if (CF > 0) begin
            m_phase = 2;
            m_left  = CF;
        end else begin
            m_phase = 0;
            m_left  = 0;
        end
    endtask

    task automatic model_edge(input bit [3:0] r, input bit s, input bit c);
        bit [3:0] cand;
        int       pick;
        m_pulse = 1'b0;
        if (m_phase == 0) begin
            cand = m_pend | r;
            if (cand != 4'b0000) begin
                pick = -1;
                for (int k = 1; k <= N; k++)
                    if (pick < 0 && cand[(m_owner + k) % N]) pick = (m_owner + k) % N;
                m_owner = pick;
                m_phase = 1;
                m_pulse = 1'b1;
                m_left  = PF;
                cand[pick] = 1'b0;
            end
            m_pend = cand;
        end else if (m_phase == 1) begin
            for (int k = 0; k < N; k++)
                if (r[k] && k != m_owner) m_pend[k] = 1'b1;
            if (c) end_powerup();
            else if (r[m_owner]) m_left = PF;
            else if (s) begin
                if (m_left == 1) end_powerup();
                else m_left = m_left - 1;
            end
        end else begin
            m_pend = m_pend | r;
            if (s) begin
                if (m_left == 1) begin
                    m_phase = 0;
                    m_left  = 0;
                end else m_left = m_left - 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".active"}, 32'(bus.powerup_active), 32'(m_phase == 1));
        cmp({tag, ".pulse"},  32'(bus.grant_pulse),    32'(m_pulse));
        cmp({tag, ".id"},     32'(bus.grant_id),       32'(m_owner));
        cmp({tag, ".left"},   32'(bus.frames_left),    32'(m_left));
        cmp({tag, ".pend"},   32'(bus.pending),        32'(m_pend));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after.
    task automatic step(input string tag, input bit [3:0] r, input bit s, input bit c);
        bus.req            = r;
        bus.start_of_frame = s;
        bus.cancel         = c;
        @(posedge clk);
        model_edge(r, s, c);
        #1;
        bus.req            = 4'b0000;
        bus.start_of_frame = 1'b0;
        bus.cancel         = 1'b0;
        check_model(tag);
    endtask

    task automatic check_reset_values(input string tag);
        cmp({tag, ".active"}, 32'(bus.powerup_active), 32'd0);
        cmp({tag, ".pulse"},  32'(bus.grant_pulse),    32'd0);
        cmp({tag, ".left"},   32'(bus.frames_left),    32'd0);
        cmp({tag, ".pend"},   32'(bus.pending),        32'd0);
        cmp({tag, ".id"},     32'(bus.grant_id),       32'd3);
    endtask

    // Assert reset a few ns into a cycle, check it took effect at once, release later.
    task automatic async_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_values(tag);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values({tag, ".held"});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.req            = 4'b0000;
        bus.start_of_frame = 1'b0;
        bus.cancel         = 1'b0;
        reset              = 1'b1;
        model_reset();
        #1;
        check_reset_values("por");
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Single request: grant, 3 frames active, 2 frames lockout.
        step("r17.grant", 4'b0001, 1'b0, 1'b0);
        cmp("r17.left3", 32'(bus.frames_left), 32'd3);
        step("r17.gap", 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("r17.act", 4'b0000, 1'b1, 1'b0);
        cmp("r17.cool2", 32'(bus.frames_left), 32'd2);
        cmp("r17.off", 32'(bus.powerup_active), 32'd0);
        for (int i = 0; i < 2; i++) step("r17.cool", 4'b0000, 1'b1, 1'b0);
        cmp("r17.idle0", 32'(bus.frames_left), 32'd0);

        // Round-robin from a freshly reset grant pointer.
        async_reset("rst1");
        step("r18.g0", 4'b1011, 1'b0, 1'b0);
        cmp("r18.pend1", 32'(bus.pending), 32'h0A);
        step("r18.req_in_cool", 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("r18.run0", 4'b0000, 1'b1, 1'b0);
        step("r18.g1", 4'b0000, 1'b0, 1'b0);
        cmp("r18.id1", 32'(bus.grant_id), 32'd1);
        cmp("r18.pend2", 32'(bus.pending), 32'h08);
        for (int i = 0; i < 5; i++) step("r18.run1", 4'b0000, 1'b1, 1'b0);
        step("r18.g3", 4'b0000, 1'b0, 1'b0);
        cmp("r18.id3", 32'(bus.grant_id), 32'd3);
        for (int i = 0; i < 5; i++) step("r18.run3", 4'b0000, 1'b1, 1'b0);

        // Retrigger on the last frame.
        step("r19.g2", 4'b0100, 1'b0, 1'b0);
        step("r19.f2", 4'b0000, 1'b1, 1'b0);
        step("r19.f1", 4'b0000, 1'b1, 1'b0);
        step("r19.retrig", 4'b0100, 1'b1, 1'b0);
        cmp("r19.left", 32'(bus.frames_left), 32'd3);
        cmp("r19.pend", 32'(bus.pending), 32'd0);
        cmp("r19.stay", 32'(bus.powerup_active), 32'd1);
        step("r19.cancel", 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step("r19.cool", 4'b0000, 1'b1, 1'b0);

        // Cancel with a simultaneous request from another requester.
        step("r20.g0", 4'b0001, 1'b0, 1'b0);
        step("r20.cancel", 4'b0010, 1'b0, 1'b1);
        cmp("r20.left", 32'(bus.frames_left), 32'd2);
        cmp("r20.pend", 32'(bus.pending), 32'h02);
        step("r20.ign_cancel", 4'b0000, 1'b1, 1'b1);
        step("r20.cool", 4'b0000, 1'b1, 1'b0);
        step("r20.g1", 4'b0000, 1'b0, 1'b0);
        cmp("r20.id1", 32'(bus.grant_id), 32'd1);
        cmp("r20.pulse", 32'(bus.grant_pulse), 32'd1);
        step("r20.exit", 4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step("r20.cool2", 4'b0000, 1'b1, 1'b0);

        // Reset in the middle of a power-up with queued requests.
        step("r21.g0", 4'b0001, 1'b0, 1'b0);
        step("r21.queue", 4'b1100, 1'b0, 1'b0);
        cmp("r21.pend", 32'(bus.pending), 32'h0C);
        async_reset("r21.rst");
        step("r21.g3", 4'b1000, 1'b0, 1'b0);
        cmp("r21.id3", 32'(bus.grant_id), 32'd3);
        cmp("r21.on", 32'(bus.powerup_active), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit [3:0] r;
            for (int k = 0; k < N; k++) r[k] = ($urandom_range(0, 7) == 0);
            step("rand", r, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_powerup_scheduler
